// File: rtl/cache_traffic_generator.sv
// cache_traffic_generator
//
// Synthetic core that drives the core port of cache_level_1. It issues a
// strided sequence of reads and/or writes and keeps one transaction in flight
// at a time. In write-then-verify mode it checks the read-back data.
//
// Ports:
//   clock_i, resetn_i        clock and asynchronous active-low reset
//   start_i                  launches a run when idle (ignored otherwise)
//   mode_i                   00 read, 01 write, 10 write then verify, 11 as 00
//   base_addr_i, stride_i    first byte address and byte step per transaction
//   count_i                  transactions per pass (0 = finish with no traffic)
//   busy_o, done_o           run in progress / one-cycle end-of-run pulse
//   error_o, timeout_o       sticky status of the last run
//   error_count_o            verify mismatches (saturating)
//   cycles_o                 busy cycles of the last run (saturating)
//   latency_max_o            worst read latency, 0 unless latency is enabled
//   stall_i                  cache back-pressure, holds the current request
//   core_request_o, core_wren_o, core_addr_o, core_data_o   request to cache
//   core_valid_i, core_data_i                               read response
//
// Build option: define CACHE_TRAFFIC_LATENCY_EN to build the read latency
// counter behind latency_max_o.

module cache_traffic_generator #(
   parameter int unsigned BW_CORE_ADDR_BYTE = 32,
   parameter int unsigned BW_DATA_WORD      = 32,
   parameter int unsigned BW_COUNT          = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 1024,
   parameter logic [BW_DATA_WORD-1:0] DATA_KEY = 32'hA5A5_A5A5
) (
   input  logic                         clock_i,
   input  logic                         resetn_i,
   input  logic                         start_i,
   input  logic [1:0]                   mode_i,
   input  logic [BW_CORE_ADDR_BYTE-1:0] base_addr_i,
   input  logic [BW_CORE_ADDR_BYTE-1:0] stride_i,
   input  logic [BW_COUNT-1:0]          count_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o,
   output logic                         timeout_o,
   output logic [BW_COUNT-1:0]          error_count_o,
   output logic [31:0]                  cycles_o,
   output logic [15:0]                  latency_max_o,
   input  logic                         stall_i,
   output logic                         core_request_o,
   output logic                         core_wren_o,
   output logic [BW_CORE_ADDR_BYTE-1:0] core_addr_o,
   output logic [BW_DATA_WORD-1:0]      core_data_o,
   input  logic                         core_valid_i,
   input  logic [BW_DATA_WORD-1:0]      core_data_i
);

   localparam int unsigned WaitW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WaitW-1:0]    WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
   localparam logic [WaitW-1:0]    WaitOne  = WaitW'(1);
   localparam logic [BW_COUNT-1:0] CountOne = BW_COUNT'(1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitRd,
      StNext,
      StPass2,
      StDone
   } state_e;

   state_e                         state_q, state_d;
   logic [1:0]                     mode_q;
   logic                           pass_q;     // 1 = verify pass of mode 10
   logic [BW_CORE_ADDR_BYTE-1:0]   base_q, stride_q, acc_q;
   logic [BW_COUNT-1:0]            count_q, idx_q;
   logic [WaitW-1:0]               wait_q;
   logic                           done_q, error_q, timeout_q;
   logic [BW_COUNT-1:0]            error_count_q;
   logic [31:0]                    cycles_q;

   logic                           is_write, verify, issue, accept, last, wait_last;
   logic                           rsp, rsp_mismatch;
   logic [BW_CORE_ADDR_BYTE-1:0]   addr_aligned;
   logic [BW_DATA_WORD-1:0]        pattern;

   assign is_write     = (mode_q == 2'b01) || ((mode_q == 2'b10) && !pass_q);
   assign verify       = (mode_q == 2'b10) && pass_q;
   assign issue        = (state_q == StIssue);
   assign accept       = issue && !stall_i;
   assign addr_aligned = {acc_q[BW_CORE_ADDR_BYTE-1:2], 2'b00};
   assign pattern      = BW_DATA_WORD'(addr_aligned) ^ DATA_KEY;
   assign last         = ({1'b0, idx_q} + {1'b0, CountOne}) == {1'b0, count_q};
   assign wait_last    = (wait_q == WaitLast);

   // A response in the acceptance cycle counts; otherwise only WAIT_RD listens.
   assign rsp          = core_valid_i &&
                         ((accept && !is_write) || (state_q == StWaitRd));
   assign rsp_mismatch = rsp && verify && (core_data_i != pattern);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = (count_i == '0) ? StDone : StIssue;
         end
         StIssue: begin
            if (!stall_i) state_d = (is_write || core_valid_i) ? StNext : StWaitRd;
         end
         StWaitRd: begin
            if (core_valid_i)   state_d = StNext;
            else if (wait_last) state_d = StDone;
         end
         StNext: begin
            if (!last)                              state_d = StIssue;
            else if ((mode_q == 2'b10) && !pass_q)  state_d = StPass2;
            else                                    state_d = StDone;
         end
         StPass2: state_d = StIssue;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         mode_q        <= 2'b00;
         pass_q        <= 1'b0;
         base_q        <= '0;
         stride_q      <= '0;
         acc_q         <= '0;
         count_q       <= '0;
         idx_q         <= '0;
         wait_q        <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         timeout_q     <= 1'b0;
         error_count_q <= '0;
         cycles_q      <= '0;
      end else begin
         // done_o trails the DONE state by one cycle, when busy_o is already low
         done_q <= (state_q == StDone);
         if ((state_q != StIdle) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  mode_q        <= (mode_i == 2'b11) ? 2'b00 : mode_i;
                  pass_q        <= 1'b0;
                  base_q        <= base_addr_i;
                  stride_q      <= stride_i;
                  acc_q         <= base_addr_i;
                  count_q       <= count_i;
                  idx_q         <= '0;
                  error_q       <= 1'b0;
                  timeout_q     <= 1'b0;
                  error_count_q <= '0;
                  cycles_q      <= '0;
               end
            end
            StIssue: begin
               if (accept) wait_q <= '0;
            end
            StWaitRd: begin
               if (!core_valid_i) begin
                  wait_q <= wait_q + WaitOne;
                  if (wait_last) begin
                     timeout_q <= 1'b1;
                     error_q   <= 1'b1;
                  end
               end
            end
            StNext: begin
               idx_q <= idx_q + CountOne;
               acc_q <= acc_q + stride_q;
            end
            StPass2: begin
               idx_q  <= '0;
               acc_q  <= base_q;
               pass_q <= 1'b1;
            end
            default: ;
         endcase
         if (rsp_mismatch) begin
            error_q <= 1'b1;
            if (error_count_q != '1) error_count_q <= error_count_q + CountOne;
         end
      end
   end

`ifdef CACHE_TRAFFIC_LATENCY_EN
   logic [15:0] lat_cnt_q, lat_max_q;

   // lat_cnt_q holds the latency a response would have if it arrived this cycle.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         lat_cnt_q <= '0;
         lat_max_q <= '0;
      end else begin
         if ((state_q == StIdle) && start_i) begin
            lat_max_q <= '0;
         end
         if (accept && !is_write) begin
            lat_cnt_q <= 16'd1;
         end else if (state_q == StWaitRd) begin
            if (core_valid_i) begin
               if (lat_cnt_q > lat_max_q) lat_max_q <= lat_cnt_q;
            end else if (lat_cnt_q != 16'hFFFF) begin
               lat_cnt_q <= lat_cnt_q + 16'd1;
            end
         end
      end
   end

   assign latency_max_o = lat_max_q;
`else
   assign latency_max_o = '0;
`endif

   assign busy_o         = (state_q != StIdle);
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign timeout_o      = timeout_q;
   assign error_count_o  = error_count_q;
   assign cycles_o       = cycles_q;
   assign core_request_o = issue;
   assign core_wren_o    = issue && is_write;
   assign core_addr_o    = issue ? addr_aligned : '0;
   assign core_data_o    = (issue && is_write) ? pattern : '0;

endmodule
